// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - icache/dcache/RAM bus bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;

    // Arbiter side: consumes cache requests and RAM responses.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Environment side: caches and RAM.
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter onto single-ported RAM with watchdog; ARB_RR_EN selects round-robin
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus,
    output logic          err_tmo
);
    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;
    typedef enum logic {SRV_I, SRV_D} srv_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYC - 1);

    state_t     state_q, state_d;
    srv_t       last_srv_q, last_srv_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       err_tmo_q, err_tmo_d;

    logic access, i_req, d_req, owner_req;

    assign access  = (bus.ramstate == RAM_ACCESS);
    assign i_req   = bus.iREN;
    assign d_req   = bus.dREN | bus.dWEN;
    assign err_tmo = err_tmo_q;

    // Next grant, service history and watchdog.
    always_comb begin
        state_d    = state_q;
        last_srv_d = last_srv_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_tmo_d  = err_tmo_q;
        owner_req  = (state_q == IGNT) ? i_req : d_req;
        case (state_q)
            IDLE: begin
                tmo_cnt_d = 8'd0;
                if (d_req && i_req) begin
`ifdef ARB_RR_EN
                    state_d = (last_srv_q == SRV_D) ? IGNT : DGNT;
`else
                    state_d = DGNT;
`endif
                end else if (d_req) begin
                    state_d = DGNT;
                end else if (i_req) begin
                    state_d = IGNT;
                end
            end
            IGNT, DGNT: begin
                if (access) begin
                    state_d    = IDLE;
                    tmo_cnt_d  = 8'd0;
                    last_srv_d = (state_q == IGNT) ? SRV_I : SRV_D;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Watchdog abort: no ack, just release the RAM.
                    state_d   = IDLE;
                    tmo_cnt_d = 8'd0;
                    err_tmo_d = 1'b1;
                end else if (!owner_req) begin
                    state_d   = IDLE;
                    tmo_cnt_d = 8'd0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM strobes and cache acks, steered by the current grant.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = {ADDR_W{1'b0}};
        bus.ramstore = {DATA_W{1'b0}};
        bus.iwait    = 1'b1;
        bus.iload    = {DATA_W{1'b0}};
        bus.dwait    = 1'b1;
        bus.dload    = {DATA_W{1'b0}};
        case (state_q)
            IGNT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = ~access;
                bus.iload   = access ? bus.ramload : {DATA_W{1'b0}};
            end
            DGNT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dwait    = ~access;
                bus.dload    = access ? bus.ramload : {DATA_W{1'b0}};
            end
            default: ;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            last_srv_q <= SRV_I;
            tmo_cnt_q  <= 8'd0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_srv_q <= last_srv_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_tmo_q  <= err_tmo_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized check of mem_arbiter against a grant-owner model
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 8;

    logic CLK = 1'b0;
    logic RST;
    logic err_tmo;
    always #5 CLK = ~CLK;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(T)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .bus    (bus.slave),
        .err_tmo(err_tmo)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the RAM (0 none, 1 icache, 2 dcache).
    bit        model_en = 0;
    int        m_owner, m_last, m_cnt;
    bit        m_err;
    bit        acc, ireq, dreq, still;
    logic          e_ren, e_wen, e_iw, e_dw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_store, e_il, e_dl;

    always @(negedge CLK) begin
        if (model_en) begin
            acc  = (bus.ramstate == 2'd2);
            ireq = bus.iREN;
            dreq = bus.dREN || bus.dWEN;
            e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
            e_iw = 1; e_il = 0; e_dw = 1; e_dl = 0;
            if (m_owner == 1) begin
                e_ren = ireq; e_addr = bus.iaddr;
                e_iw = !acc; e_il = acc ? bus.ramload : 0;
            end else if (m_owner == 2) begin
                e_wen = bus.dWEN; e_ren = bus.dREN && !bus.dWEN;
                e_addr = bus.daddr; e_store = bus.dstore;
                e_dw = !acc; e_dl = acc ? bus.ramload : 0;
            end
            check("m_ramREN", bus.ramREN, e_ren);
            check("m_ramWEN", bus.ramWEN, e_wen);
            check("m_ramaddr", bus.ramaddr, e_addr);
            check("m_ramstore", bus.ramstore, e_store);
            check("m_iwait", bus.iwait, e_iw);
            check("m_iload", bus.iload, e_il);
            check("m_dwait", bus.dwait, e_dw);
            check("m_dload", bus.dload, e_dl);
            check("m_err_tmo", err_tmo, m_err);
            if (RST) begin
                m_owner = 0; m_last = 1; m_cnt = 0; m_err = 0;
            end else if (m_owner == 0) begin
                m_cnt = 0;
                if (ireq && dreq) begin
`ifdef ARB_RR_EN
                    m_owner = (m_last == 2) ? 1 : 2;
`else
                    m_owner = 2;
`endif
                end else if (dreq) m_owner = 2;
                else if (ireq) m_owner = 1;
            end else begin
                still = (m_owner == 1) ? ireq : dreq;
                if (acc) begin
                    m_last = m_owner; m_owner = 0; m_cnt = 0;
                end else if (m_cnt == T - 1) begin
                    m_err = 1; m_owner = 0; m_cnt = 0;
                end else if (!still) begin
                    m_owner = 0; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiesce();
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.ramstate = 2'd0;
        repeat (3) tick();
    endtask

    int n_i, n_d, n_gnt;
    bit saw_iack;

    initial begin
        RST = 1;
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = 0;
        tick(); tick();
        m_owner = 0; m_last = 1; m_cnt = 0; m_err = 0;
        model_en = 1;
        @(negedge CLK);
        check("rst_iwait", bus.iwait, 1);
        check("rst_dwait", bus.dwait, 1);
        check("rst_ramREN", bus.ramREN, 0);
        check("rst_err", err_tmo, 0);
        tick();
        RST = 0;
        tick();

        // Test 1: icache read, two BUSY cycles then ACCESS.
        bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = 2'd1;
        @(negedge CLK); check("t1_idle_ren", bus.ramREN, 0);
        tick();
        @(negedge CLK); check("t1_ren", bus.ramREN, 1); check("t1_addr", bus.ramaddr, 32'h40);
        tick();
        tick(); bus.ramstate = 2'd2; bus.ramload = 32'h2402000A;
        @(negedge CLK); check("t1_iwait", bus.iwait, 0); check("t1_iload", bus.iload, 32'h2402000A);
        tick(); bus.iREN = 0; bus.ramstate = 2'd0;
        @(negedge CLK); check("t1_after_iwait", bus.iwait, 1); check("t1_after_ren", bus.ramREN, 0);
        quiesce();

        // Test 2: dcache write acked on the first grant cycle.
        bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'hDEADBEEF; bus.ramstate = 2'd2;
        @(negedge CLK); check("t2_idle_dwait", bus.dwait, 1);
        tick();
        @(negedge CLK);
        check("t2_wen", bus.ramWEN, 1); check("t2_addr", bus.ramaddr, 32'h80);
        check("t2_store", bus.ramstore, 32'hDEADBEEF); check("t2_dwait", bus.dwait, 0);
        tick();
        @(negedge CLK); check("t2_dwait_1cyc", bus.dwait, 1);
        quiesce();

        // Test 3: both requesting, RAM acks whenever strobed.
        bus.iREN = 1; bus.dREN = 1; bus.ramstate = 2'd2;
        n_i = 0; n_d = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (!bus.iwait) n_i++;
            if (!bus.dwait) n_d++;
            tick();
        end
`ifdef ARB_RR_EN
        check("t3_i_acks", n_i, 2); check("t3_d_acks", n_d, 2);
`else
        check("t3_i_acks", n_i, 0); check("t3_d_acks", n_d, 4);
`endif
        quiesce();

        // Test 4: RAM ERROR is retried, not completed.
        bus.dREN = 1; bus.daddr = 32'h100; bus.ramstate = 2'd3;
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); check("t4_err_dwait", bus.dwait, 1); check("t4_err_ren", bus.ramREN, 1);
            tick();
        end
        bus.ramstate = 2'd2;
        @(negedge CLK); check("t4_acc_dwait", bus.dwait, 0); check("t4_err_tmo", err_tmo, 0);
        quiesce();

        // Test 5: watchdog abort after exactly T grant cycles.
        bus.iREN = 1; bus.iaddr = 32'h44; bus.ramstate = 2'd1;
        n_gnt = 0; saw_iack = 0;
        @(negedge CLK); check("t5_pre_err", err_tmo, 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            @(negedge CLK);
            if (!bus.iwait) saw_iack = 1;
            if (!bus.ramREN) break;
            n_gnt++;
        end
        check("t5_gnt_cycles", n_gnt, T);
        check("t5_err_tmo", err_tmo, 1);
        check("t5_no_ack", saw_iack, 0);
        quiesce();
        @(negedge CLK); check("t5_sticky", err_tmo, 1);

        // Test 6: reset in the middle of a dcache grant.
        bus.dWEN = 1; bus.daddr = 32'hC0; bus.ramstate = 2'd1;
        tick();
        @(negedge CLK); check("t6_wen_pre", bus.ramWEN, 1);
        tick(); RST = 1;
        tick(); RST = 0;
        @(negedge CLK);
        check("t6_wen", bus.ramWEN, 0); check("t6_dwait", bus.dwait, 1); check("t6_err", err_tmo, 0);
        quiesce();

        // Randomized traffic checked by the model every cycle.
        for (int k = 0; k < 1500; k++) begin
            tick();
            if ($urandom_range(0, 3) == 0) bus.iREN = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) bus.dREN = $urandom_range(0, 1);
            if ($urandom_range(0, 4) == 0) bus.dWEN = $urandom_range(0, 1);
            bus.iaddr   = $urandom;
            bus.daddr   = $urandom;
            bus.dstore  = $urandom;
            bus.ramload = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2:    bus.ramstate = 2'd2;
                3:          bus.ramstate = 2'd3;
                4:          bus.ramstate = 2'd0;
                default:    bus.ramstate = 2'd1;
            endcase
            RST = ($urandom_range(0, 199) == 0);
        end
        tick();
        RST = 0;
        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
